sdram_arbiter: RTL and testbench

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_arbiter.sv | 144 ++++++++++++++
 tb/tb_sdram_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// Two-port SDRAM access arbiter: a CPU single-word port and a video read-burst
// port share one SDRAM controller, with periodic refresh taking precedence.
module sdram_arbiter #(
  parameter int REFRESH_INTERVAL = 390
) (
  input  logic        sdram_clock,
  input  logic        sdram_reset_n,
  input  logic        cpu_req,
  input  logic        cpu_write,
  input  logic [24:0] cpu_address,
  input  logic [15:0] cpu_data_in,
  output logic [15:0] cpu_data_out,
  output logic        cpu_ack,
  input  logic        vid_req,
  input  logic [24:0] vid_address,
  input  logic [9:0]  vid_num,
  output logic [15:0] vid_data,
  output logic        vid_data_valid,
  output logic        vid_ack,
  output logic [24:0] address,
  output logic [9:0]  access_num,
  output logic [15:0] data_in,
  output logic        write_request,
  output logic        read_request,
  output logic        enable_refresh,
  input  logic        write_flag,
  input  logic        read_flag,
  input  logic        idle,
  input  logic        refresh_mode,
  input  logic [15:0] data_out
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] REF_START = 3'd1;
  localparam logic [2:0] REF_WAIT  = 3'd2;
  localparam logic [2:0] CPU_REQ   = 3'd3;
  localparam logic [2:0] CPU_XFER  = 3'd4;
  localparam logic [2:0] VID_REQ   = 3'd5;
  localparam logic [2:0] VID_XFER  = 3'd6;
  localparam logic [2:0] DONE      = 3'd7;

  localparam logic [15:0] REF_LIM = 16'(REFRESH_INTERVAL);

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [15:0] ref_cnt;
  logic        refresh_due;
  logic        ref_hold;
  logic        last_vid;
  logic        gnt_vid;
  logic        lat_write;
  logic [24:0] lat_addr;
  logic [15:0] lat_data;
  logic [9:0]  lat_num;
  logic        granted;
  logic        cpu_flag;
  logic        go_cpu;
  logic        go_vid;

  assign refresh_due = (ref_cnt >= REF_LIM);
  assign cpu_flag    = lat_write ? write_flag : read_flag;
  assign go_cpu      = (state == IDLE) && (state_nxt == CPU_REQ);
  assign go_vid      = (state == IDLE) && (state_nxt == VID_REQ);

  // Tie between both ports goes to whichever was not served last
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (idle) begin
          if (refresh_due)                           state_nxt = REF_START;
          else if (cpu_req && (!vid_req || last_vid)) state_nxt = CPU_REQ;
          else if (vid_req)                          state_nxt = VID_REQ;
        end
      end
      REF_START: state_nxt = REF_WAIT;
      REF_WAIT:  if (ref_hold && !refresh_mode && idle) state_nxt = IDLE;
      CPU_REQ:   if (cpu_flag) state_nxt = CPU_XFER;
      CPU_XFER:  if (!cpu_flag) state_nxt = DONE;
      VID_REQ:   if (read_flag) state_nxt = VID_XFER;
      VID_XFER:  if (!read_flag) state_nxt = DONE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sdram_clock or negedge sdram_reset_n) begin
    if (!sdram_reset_n) begin
      state        <= IDLE;
      ref_cnt      <= 16'd0;
      ref_hold     <= 1'b0;
      last_vid     <= 1'b1;
      gnt_vid      <= 1'b0;
      lat_write    <= 1'b0;
      cpu_data_out <= 16'd0;
    end else begin
      state    <= state_nxt;
      ref_hold <= (state == REF_WAIT);
      if ((state == IDLE) && (state_nxt == REF_START))
        ref_cnt <= 16'd0;
      else if (ref_cnt != 16'hFFFF)
        ref_cnt <= ref_cnt + 16'd1;
      if (go_cpu) begin
        gnt_vid   <= 1'b0;
        lat_write <= cpu_write;
      end else if (go_vid) begin
        gnt_vid   <= 1'b1;
        lat_write <= 1'b0;
      end
      if (state == DONE)
        last_vid <= gnt_vid;
      if ((state == CPU_XFER) && !lat_write && read_flag)
        cpu_data_out <= data_out;
    end
  end

  // Request parameters are frozen at grant; later requester changes are ignored
  always_ff @(posedge sdram_clock) begin
    if (go_cpu) begin
      lat_addr <= cpu_address;
      lat_data <= cpu_data_in;
      lat_num  <= 10'd1;
    end else if (go_vid) begin
      lat_addr <= vid_address;
      lat_data <= 16'd0;
      lat_num  <= (vid_num == 10'd0) ? 10'd1 : vid_num;
    end
  end

  assign granted = (state == CPU_REQ) || (state == CPU_XFER) ||
                   (state == VID_REQ) || (state == VID_XFER);

  assign address        = granted ? lat_addr : 25'd0;
  assign access_num     = granted ? lat_num : 10'd0;
  assign data_in        = (granted && lat_write) ? lat_data : 16'd0;
  assign write_request  = (state == CPU_REQ) && lat_write;
  assign read_request   = ((state == CPU_REQ) && !lat_write) || (state == VID_REQ);
  assign enable_refresh = (state == REF_START);
  assign cpu_ack        = (state == DONE) && !gnt_vid;
  assign vid_ack        = (state == DONE) && gnt_vid;
  assign vid_data       = (state == VID_XFER) ? data_out : 16'd0;
  assign vid_data_valid = (state == VID_XFER) && read_flag;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a small behavioural SDRAM controller model.
module tb_sdram_arbiter;

  logic        sdram_clock = 1'b0;
  logic        sdram_reset_n;
  logic        cpu_req, cpu_write;
  logic [24:0] cpu_address;
  logic [15:0] cpu_data_in, cpu_data_out;
  logic        cpu_ack;
  logic        vid_req;
  logic [24:0] vid_address;
  logic [9:0]  vid_num;
  logic [15:0] vid_data;
  logic        vid_data_valid, vid_ack;
  logic [24:0] address;
  logic [9:0]  access_num;
  logic [15:0] data_in;
  logic        write_request, read_request, enable_refresh;
  logic        write_flag, read_flag, idle, refresh_mode;
  logic [15:0] data_out;

  logic [15:0] rd_base;
  int          n_pass = 0;
  int          n_checks = 0;

  always #5 sdram_clock = ~sdram_clock;

  sdram_arbiter #(.REFRESH_INTERVAL(16)) dut (
    .sdram_clock(sdram_clock), .sdram_reset_n(sdram_reset_n),
    .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_address(cpu_address),
    .cpu_data_in(cpu_data_in), .cpu_data_out(cpu_data_out), .cpu_ack(cpu_ack),
    .vid_req(vid_req), .vid_address(vid_address), .vid_num(vid_num),
    .vid_data(vid_data), .vid_data_valid(vid_data_valid), .vid_ack(vid_ack),
    .address(address), .access_num(access_num), .data_in(data_in),
    .write_request(write_request), .read_request(read_request),
    .enable_refresh(enable_refresh), .write_flag(write_flag), .read_flag(read_flag),
    .idle(idle), .refresh_mode(refresh_mode), .data_out(data_out)
  );

  // Controller model: refresh busy 3 cycles, write flag 2 cycles,
  // read flag access_num+1 cycles with data rd_base, rd_base+1, ...
  initial begin
    int busy;
    busy = 0;
    idle = 1'b1; write_flag = 1'b0; read_flag = 1'b0; refresh_mode = 1'b0; data_out = 16'd0;
    forever begin
      @(posedge sdram_clock); #1;
      if (!sdram_reset_n) begin
        busy = 0; idle = 1'b1; write_flag = 1'b0; read_flag = 1'b0; refresh_mode = 1'b0;
      end else if (busy > 0) begin
        busy--;
        if (busy == 0) begin
          idle = 1'b1; write_flag = 1'b0; read_flag = 1'b0; refresh_mode = 1'b0;
        end else begin
          data_out = data_out + 16'd1;
        end
      end else if (enable_refresh) begin
        idle = 1'b0; refresh_mode = 1'b1; busy = 3;
      end else if (write_request) begin
        idle = 1'b0; write_flag = 1'b1; busy = 2;
      end else if (read_request) begin
        idle = 1'b0; read_flag = 1'b1; data_out = rd_base; busy = int'(access_num) + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      0:       pick = write_request;
      1:       pick = read_request;
      2:       pick = cpu_ack;
      3:       pick = vid_ack;
      default: pick = enable_refresh;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int limit, input string tag);
    int i;
    i = 0;
    do begin
      @(negedge sdram_clock);
      i++;
    end while (!pick(sel) && i < limit);
    check(tag, 32'(pick(sel)), 32'd1);
  endtask

  task automatic collect(input int limit, output int cnt, output logic [15:0] first,
                         output logic [15:0] last);
    int i;
    cnt = 0; first = 16'd0; last = 16'd0; i = 0;
    do begin
      @(negedge sdram_clock);
      i++;
      if (vid_data_valid) begin
        if (cnt == 0) first = vid_data;
        last = vid_data;
        cnt++;
      end
    end while (!vid_ack && i < limit);
    check("vid_ack_seen", 32'(vid_ack), 32'd1);
  endtask

  initial begin
    int          cnt, gap, acks;
    logic [15:0] first, last;
    logic        ref_first;

    sdram_reset_n = 1'b0;
    cpu_req = 1'b0; cpu_write = 1'b0; cpu_address = 25'd0; cpu_data_in = 16'd0;
    vid_req = 1'b0; vid_address = 25'd0; vid_num = 10'd0; rd_base = 16'd0;
    repeat (3) @(negedge sdram_clock);
    check("rst_ctrl", 32'({write_request, read_request, enable_refresh, cpu_ack, vid_ack,
                           vid_data_valid}), 32'd0);
    check("rst_address", 32'(address), 32'd0);
    check("rst_cpu_data_out", 32'(cpu_data_out), 32'd0);

    // Simultaneous requests right after reset: CPU write first, then video burst of 8
    sdram_reset_n = 1'b1;
    cpu_req = 1'b1; cpu_write = 1'b1; cpu_address = 25'h0001234; cpu_data_in = 16'hBEEF;
    vid_req = 1'b1; vid_address = 25'h1000000; vid_num = 10'd8; rd_base = 16'h0100;
    wait_for(0, 40, "cpu_write_request");
    check("wr_address", 32'(address), 32'h0001234);
    check("wr_access_num", 32'(access_num), 32'd1);
    check("wr_data_in", 32'(data_in), 32'hBEEF);
    check("wr_no_vid_read", 32'(read_request), 32'd0);
    cpu_address = 25'h1FFFFFF; cpu_data_in = 16'h0000;
    @(negedge sdram_clock);
    check("wr_addr_latched", 32'(address), 32'h0001234);
    check("wr_data_latched", 32'(data_in), 32'hBEEF);
    wait_for(2, 40, "cpu_write_ack");
    check("wr_flag_low_at_ack", 32'(write_flag), 32'd0);
    cpu_req = 1'b0;
    @(negedge sdram_clock);
    check("cpu_ack_one_cycle", 32'(cpu_ack), 32'd0);
    wait_for(1, 40, "vid_read_request");
    check("vid_address", 32'(address), 32'h1000000);
    check("vid_access_num", 32'(access_num), 32'd8);
    vid_address = 25'h0000000;
    collect(60, cnt, first, last);
    vid_req = 1'b0;
    check("vid8_valid_count", 32'(cnt), 32'd8);
    check("vid8_first", 32'(first), 32'h0101);
    check("vid8_last", 32'(last), 32'h0108);

    // CPU read, data held after ack
    rd_base = 16'h5A59;
    cpu_write = 1'b0; cpu_address = 25'h0000ABC; cpu_req = 1'b1;
    wait_for(1, 40, "cpu_read_request");
    check("rd_access_num", 32'(access_num), 32'd1);
    check("rd_data_in_zero", 32'(data_in), 32'd0);
    check("rd_no_write_req", 32'(write_request), 32'd0);
    wait_for(2, 40, "cpu_read_ack");
    cpu_req = 1'b0;
    check("rd_cpu_data_out", 32'(cpu_data_out), 32'h5A5A);
    repeat (5) @(negedge sdram_clock);
    check("rd_cpu_data_hold", 32'(cpu_data_out), 32'h5A5A);

    // Idle refresh cadence: counter cleared at REF_START, due after 16 more cycles
    wait_for(4, 60, "refresh_seen");
    @(negedge sdram_clock);
    check("refresh_single_cycle", 32'(enable_refresh), 32'd0);
    gap = 1;
    while (!enable_refresh && gap < 60) begin
      @(negedge sdram_clock);
      gap++;
    end
    check("refresh_gap", 32'(gap), 32'd17);

    // Request raised during refresh must wait for refresh completion
    rd_base = 16'h1111; cpu_write = 1'b0; cpu_address = 25'h0000042; cpu_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge sdram_clock);
      check("held_during_refresh", 32'(read_request), 32'd0);
    end
    wait_for(1, 10, "cpu_after_refresh");
    check("cpu_after_refresh_addr", 32'(address), 32'h0000042);
    wait_for(2, 40, "cpu_after_refresh_ack");
    cpu_req = 1'b0;
    check("cpu_after_refresh_data", 32'(cpu_data_out), 32'h1112);

    // Long burst with refresh coming due mid-transfer; video request drops mid-burst
    rd_base = 16'h2000; vid_address = 25'h00ABCDE; vid_num = 10'd40; vid_req = 1'b1;
    wait_for(1, 40, "vid40_request");
    check("vid40_access_num", 32'(access_num), 32'd40);
    vid_req = 1'b0;
    cpu_write = 1'b0; cpu_address = 25'h0000055; cpu_req = 1'b1;
    collect(100, cnt, first, last);
    check("vid40_valid_count", 32'(cnt), 32'd40);
    check("vid40_first", 32'(first), 32'h2001);
    check("vid40_last", 32'(last), 32'h2028);
    rd_base = 16'h2FFF;
    ref_first = 1'b0;
    for (int k = 0; k < 60 && !read_request; k++) begin
      @(negedge sdram_clock);
      if (enable_refresh) ref_first = 1'b1;
    end
    check("cpu_grant_after_burst", 32'(read_request), 32'd1);
    check("refresh_before_cpu", 32'(ref_first), 32'd1);
    wait_for(2, 40, "cpu_after_burst_ack");
    cpu_req = 1'b0;
    check("cpu_after_burst_data", 32'(cpu_data_out), 32'h3000);

    // Zero-length video burst behaves as one word
    rd_base = 16'h4000; vid_address = 25'h0000300; vid_num = 10'd0; vid_req = 1'b1;
    wait_for(1, 40, "vid0_request");
    check("vid0_access_num", 32'(access_num), 32'd1);
    collect(40, cnt, first, last);
    vid_req = 1'b0;
    check("vid0_valid_count", 32'(cnt), 32'd1);
    check("vid0_first", 32'(first), 32'h4001);

    // Reset during CPU_XFER abandons the write with no ack
    cpu_write = 1'b1; cpu_address = 25'h0000077; cpu_data_in = 16'h1234; cpu_req = 1'b1;
    wait_for(0, 40, "xfer_write_request");
    @(negedge sdram_clock);
    check("in_xfer_req_low", 32'(write_request), 32'd0);
    check("in_xfer_address", 32'(address), 32'h0000077);
    sdram_reset_n = 1'b0;
    #1;
    check("async_rst_address", 32'(address), 32'd0);
    check("async_rst_data_in", 32'(data_in), 32'd0);
    check("async_rst_access_num", 32'(access_num), 32'd0);
    check("async_rst_ctrl", 32'({write_request, read_request, enable_refresh, cpu_ack,
                                 vid_ack}), 32'd0);
    cpu_req = 1'b0;
    acks = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge sdram_clock);
      if (k == 1) sdram_reset_n = 1'b1;
      if (cpu_ack) acks++;
    end
    check("no_ack_after_abort", 32'(acks), 32'd0);
    check("post_rst_cpu_data_out", 32'(cpu_data_out), 32'd0);
    rd_base = 16'h6000; cpu_write = 1'b0; cpu_address = 25'h0000099; cpu_req = 1'b1;
    wait_for(2, 40, "post_rst_read_ack");
    cpu_req = 1'b0;
    check("post_rst_read_data", 32'(cpu_data_out), 32'h6001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
